mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
Host-side initiator that drives the CPU's external memory access ports and its `enable` input.
- Accepts commands from a host over a valid/ready command channel: write instruction memory, write data memory, read data memory, run.
- Performs each command as a cycle-accurate transaction on the `*_ext` / `*_ext_2` ports.
- Returns read data over a valid/ready response channel.
- Sits between the testbench/host link and the cpu top; it is the only driver of the cpu's external ports and `enable`.

Parameters:
- RD_LAT, 1, cycles from `ren_ext_2` assertion to valid `rdata_ext_2` (sram read latency); legal range 1..3.
- CNT_W, 16, width of the run-cycle counter.

Ports:
- clk  in  1  main clock
- arst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader can accept a command
- cmd_op  in  2  00 IMEM write, 01 DMEM write, 10 DMEM read, 11 run
- cmd_addr  in  32  memory address, passed unchanged to addr_ext / addr_ext_2
- cmd_data  in  32  write word (ops 00/01) or run cycle count (op 11)
- rsp_valid  out  1  read data available
- rsp_ready  in  1  host accepts response
- rsp_data  out  32  captured DMEM read word
- busy  out  1  state != IDLE
- run_done  out  1  one-cycle pulse at end of a run
- enable  out  1  cpu execution enable
- addr_ext  out  32  IMEM external address
- wen_ext  out  1  IMEM external write enable
- ren_ext  out  1  IMEM external read enable (tied 0)
- wdata_ext  out  32  IMEM external write word
- rdata_ext  in  32  IMEM external read word (unused)
- addr_ext_2  out  32  DMEM external address
- wen_ext_2  out  1  DMEM external write enable
- ren_ext_2  out  1  DMEM external read enable
- wdata_ext_2  out  32  DMEM external write word
- rdata_ext_2  in  32  DMEM external read word

Behaviour:
Clock and reset
- Single clock `clk`.
- Reset `arst_n` is asynchronous, active-low. It clears all state to IDLE and all registers to 0.

Reset values
- All outputs are 0 except `cmd_ready`, which is 1.
- `cmd_ready` = (state == IDLE), decoded combinationally from the state.
- `busy` = !cmd_ready.

States: IDLE, WR_I, WR_D, RD, RESP, RUN, DONE.

IDLE
- On `cmd_valid & cmd_ready`: register `cmd_addr`/`cmd_data` and branch on `cmd_op`: 00→WR_I, 01→WR_D, 10→RD, 11→RUN.
- For op 11, load `cnt` = min(`cmd_data`, 2^CNT_W−1).
- If op 11 has `cmd_data` == 0, go directly to DONE.

WR_I (1 cycle)
- `wen_ext`=1, `addr_ext`/`wdata_ext` = registered values.
- Next state IDLE.
- Throughput is one write per 2 cycles.

WR_D (1 cycle)
- Same as WR_I, on the `_ext_2` ports.

RD (RD_LAT cycles)
- `ren_ext_2`=1 and `addr_ext_2` held for all RD_LAT cycles; a latency counter tracks them.
- On the last RD cycle, capture `rdata_ext_2` into `rsp_data`, then go to RESP.

RESP
- `rsp_valid`=1, `rsp_data` stable.
- On `rsp_ready`: go to IDLE, `rsp_valid` drops the next cycle.
- `rsp_ready` outside RESP is ignored.

RUN
- `enable`=1. `cnt` decrements each cycle.
- Leave when `cnt`==1 at a clock edge, so `enable` is high for exactly N cycles. Then go to DONE.

DONE (1 cycle)
- `run_done`=1, `enable`=0, then IDLE.

Invariants
- Every `*_ext` address, data and enable output is 0 outside its active state.
- `enable` is never high in the same cycle as any `wen`/`ren`.
- `cmd_valid` while busy is held off (`cmd_ready`=0); the command must not be lost or duplicated.
- `cmd_op`/`cmd_addr`/`cmd_data` are sampled only on the handshake edge.
- Reset mid-operation: `enable`, `wen*`, `ren*`, `rsp_valid` drop to 0 immediately (asynchronously). Any in-flight response is discarded.

Test Plan:
1. Reset, then IMEM write addr 0x4 data 0x20010005 → exactly one cycle `wen_ext`=1, `addr_ext`=0x4, `wdata_ext`=0x20010005; `cmd_ready` back to 1 the following cycle.
2. DMEM write 0x10←0xDEADBEEF, then DMEM read 0x10 with `rsp_ready`=1 → `ren_ext_2` high RD_LAT cycles; `rsp_valid` with `rsp_data`=0xDEADBEEF; repeat with RD_LAT=2 and RD_LAT=3.
3. DMEM read with `rsp_ready` low for 5 cycles → `rsp_valid`/`rsp_data` held stable for all 5 cycles; `cmd_ready`=0 throughout; single handshake then IDLE.
4. Run `cmd_data`=7 → `enable` high exactly 7 consecutive cycles; `run_done` pulse on cycle 8; no ext strobes during the run. Run 0 → no `enable`, `run_done` the cycle after accept. Run 0x1_0000 with CNT_W=16 → `enable` high exactly 65535 cycles (count clamped to 2^CNT_W−1).
5. Back-to-back `cmd_valid` held high with 3 queued writes → each accepted once, 2-cycle spacing, addresses in order.
6. `arst_n` low at cycle 3 of a 10-cycle run → `enable`=0 immediately, state IDLE, `cmd_ready`=1 after release, `run_done` never pulses.

Source files
------------

// File: rtl/mem_loader_if.sv
// Bundle of every signal between the memory loader, its host and the cpu's
// external memory/enable ports. The loader connects through `master`;
// whatever sits on the far side (host + cpu, or a bench) uses `slave`.
interface mem_loader_if;
  // host command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  // host response channel and status
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic        run_done;
  // cpu execution enable
  logic        enable;
  // instruction memory external port
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  // data memory external port
  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [31:0] wdata_ext_2;
  logic [31:0] rdata_ext_2;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  rdata_ext, rdata_ext_2,
    output cmd_ready, rsp_valid, rsp_data, busy, run_done, enable,
    output addr_ext, wen_ext, ren_ext, wdata_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output rdata_ext, rdata_ext_2,
    input  cmd_ready, rsp_valid, rsp_data, busy, run_done, enable,
    input  addr_ext, wen_ext, ren_ext, wdata_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/mem_loader.sv
// Host-side initiator for the cpu: turns host commands into single
// transactions on the IMEM/DMEM external ports, returns DMEM read data and
// gates the cpu enable for a counted number of cycles.
module mem_loader #(
  parameter int RD_LAT = 1,   // DMEM read latency in cycles, 1..3
  parameter int CNT_W  = 16   // run-cycle counter width
) (
  input logic          clk,
  input logic          arst_n,
  mem_loader_if.master bus
);

  localparam logic [1:0] OP_WR_I = 2'b00;
  localparam logic [1:0] OP_WR_D = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_RUN  = 2'b11;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_I = 3'd1,
    WR_D = 3'd2,
    RD   = 3'd3,
    RESP = 3'd4,
    RUN  = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lat;
  logic [31:0]      rsp_q;
  logic             accept;

  // Clamp a requested run length to the largest value the counter holds.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [31:0] req);
    logic [CNT_W-1:0] max_val;
    max_val = '1;
    if (64'(req) > 64'(max_val)) return max_val;
    return CNT_W'(req);
  endfunction

  assign accept = (state == IDLE) && bus.cmd_valid;

  // State register; reset returns to IDLE, which drops every strobe at once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_WR_I: state_nxt = WR_I;
            OP_WR_D: state_nxt = WR_D;
            OP_RD:   state_nxt = RD;
            OP_RUN:  state_nxt = (bus.cmd_data == 32'd0) ? DONE : RUN;
            default: state_nxt = IDLE;
          endcase
        end
      end
      WR_I:    state_nxt = IDLE;
      WR_D:    state_nxt = IDLE;
      RD:      if (lat == LAT_LAST) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      // cnt==0 cannot occur here, but leaving on it avoids a 2^CNT_W wrap
      RUN:     if (cnt <= CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, read-latency counter, run counter and read-data capture.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_q <= '0;
      data_q <= '0;
      cnt    <= '0;
      lat    <= '0;
      rsp_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.cmd_addr;
        data_q <= bus.cmd_data;
        lat    <= '0;
        if (bus.cmd_op == OP_RUN) cnt <= sat_cnt(bus.cmd_data);
      end
      if (state == RD) begin
        if (lat == LAT_LAST) rsp_q <= bus.rdata_ext_2;
        else                 lat   <= lat + 2'd1;
      end
      if (state == RUN) cnt <= cnt - CNT_W'(1);
    end
  end

  // Outputs decoded from state only; each port is zero outside its own state.
  always_comb begin
    bus.cmd_ready   = 1'b0;
    bus.busy        = 1'b1;
    bus.rsp_valid   = 1'b0;
    bus.run_done    = 1'b0;
    bus.enable      = 1'b0;
    bus.addr_ext    = '0;
    bus.wen_ext     = 1'b0;
    bus.ren_ext     = 1'b0;
    bus.wdata_ext   = '0;
    bus.addr_ext_2  = '0;
    bus.wen_ext_2   = 1'b0;
    bus.ren_ext_2   = 1'b0;
    bus.wdata_ext_2 = '0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      WR_I: begin
        bus.wen_ext   = 1'b1;
        bus.addr_ext  = addr_q;
        bus.wdata_ext = data_q;
      end
      WR_D: begin
        bus.wen_ext_2   = 1'b1;
        bus.addr_ext_2  = addr_q;
        bus.wdata_ext_2 = data_q;
      end
      RD: begin
        bus.ren_ext_2  = 1'b1;
        bus.addr_ext_2 = addr_q;
      end
      RESP:    bus.rsp_valid = 1'b1;
      RUN:     bus.enable    = 1'b1;
      DONE:    bus.run_done  = 1'b1;
      default: ;
    endcase
  end

  assign bus.rsp_data = rsp_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a vector table of write/read commands plus
// hand-written sequences for stalls, runs, back-to-back commands and reset.
`timescale 1ns/1ps
module tb_mem_loader;

  localparam int RD_LAT  = 1;
  localparam int RD_LAT3 = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  mem_loader_if bus();
  mem_loader_if bus3();

  mem_loader #(.RD_LAT(RD_LAT), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus)
  );
  mem_loader #(.RD_LAT(RD_LAT3), .CNT_W(16)) dut3 (
    .clk(clk), .arst_n(arst_n), .bus(bus3)
  );

  // DMEM model shared by both loaders; read data is only valid on the cycle
  // the loader's latency says it should sample, garbage otherwise.
  logic [31:0] dmem [16];
  int ren_run, ren_run3;

  always @(posedge clk)
    if (bus.wen_ext_2) dmem[bus.addr_ext_2[5:2]] <= bus.wdata_ext_2;

  always @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      ren_run  <= 0;
      ren_run3 <= 0;
    end else begin
      ren_run  <= bus.ren_ext_2  ? ren_run + 1  : 0;
      ren_run3 <= bus3.ren_ext_2 ? ren_run3 + 1 : 0;
    end

  assign bus.rdata_ext_2  = (bus.ren_ext_2 && ren_run == RD_LAT - 1) ?
                            dmem[bus.addr_ext_2[5:2]] : 32'hBAD0_BAD0;
  assign bus3.rdata_ext_2 = (bus3.ren_ext_2 && ren_run3 == RD_LAT3 - 1) ?
                            dmem[bus3.addr_ext_2[5:2]] : 32'hBAD0_BAD0;
  assign bus.rdata_ext  = 32'h0;
  assign bus3.rdata_ext = 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command while idle and return just after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    chk("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'hFFFF_FFFF;
    bus.cmd_data  = 32'hFFFF_FFFF;
  endtask

  // Follow a DMEM read after acceptance; rsp_ready held low for `stall` cycles.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input int stall);
    int n = 0;
    int guard = 0;
    bus.rsp_ready = (stall == 0);
    while (!bus.rsp_valid && guard < 20) begin
      if (bus.ren_ext_2) begin
        n++;
        chk("rd_addr", bus.addr_ext_2, addr);
      end
      chk("rd_no_enable", {31'd0, bus.enable}, 32'd0);
      tick();
      guard++;
    end
    chk("rd_len", n, RD_LAT);
    chk("rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_data", bus.rsp_data, exp);
      chk("stall_busy", {31'd0, bus.cmd_ready}, 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    chk("rsp_data", bus.rsp_data, exp);
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rsp_idle", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // Issue a run and count enable cycles until run_done.
  task automatic do_run(input logic [31:0] n, input int exp_en);
    int en = 0;
    int done_at = -1;
    int strb = 0;
    send_cmd(2'b11, 32'h0, n);
    for (int i = 0; i < exp_en + 20; i++) begin
      if (bus.enable) en++;
      if (bus.enable && (bus.wen_ext || bus.wen_ext_2 || bus.ren_ext_2 || bus.ren_ext)) strb++;
      if (bus.run_done) begin
        done_at = i;
        break;
      end
      tick();
    end
    chk("run_en_cycles", en, exp_en);
    chk("run_done_at", done_at, exp_en);
    chk("run_strobes", strb, 0);
    tick();
    chk("run_done_pulse", {31'd0, bus.run_done}, 32'd0);
    chk("run_idle", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] baddr [3];
    logic [31:0] got_a [3];
    int          got_c [3];
    int          got_n, k, n3, dones, ens;
    logic        rdy;

    tbl[0] = '{2'b00, 32'h0000_0004, 32'h2001_0005, 32'h0};
    tbl[1] = '{2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    tbl[2] = '{2'b10, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[3] = '{2'b01, 32'h0000_0014, 32'h1234_5678, 32'h0};
    tbl[4] = '{2'b00, 32'h0000_0008, 32'hCAFE_F00D, 32'h0};
    tbl[5] = '{2'b10, 32'h0000_0014, 32'h0,         32'h1234_5678};
    tbl[6] = '{2'b10, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};

    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    bus3.cmd_valid = 1'b0; bus3.cmd_op = 2'b00; bus3.cmd_addr = '0; bus3.cmd_data = '0;
    bus3.rsp_ready = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_enable", {31'd0, bus.enable}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_strobes", {28'd0, bus.wen_ext, bus.ren_ext, bus.wen_ext_2, bus.ren_ext_2}, 32'h0);
    chk("rst_addr", bus.addr_ext | bus.addr_ext_2, 32'h0);
    arst_n = 1'b1;
    tick();

    // vector table
    for (int i = 0; i < 7; i++) begin
      send_cmd(tbl[i].op, tbl[i].addr, tbl[i].data);
      chk("busy", {31'd0, bus.busy}, 32'd1);
      if (tbl[i].op == 2'b10) begin
        do_read(tbl[i].addr, tbl[i].exp, 0);
      end else begin
        chk("wen_i", {31'd0, bus.wen_ext}, {31'd0, tbl[i].op == 2'b00});
        chk("addr_i", bus.addr_ext, (tbl[i].op == 2'b00) ? tbl[i].addr : 32'h0);
        chk("wdata_i", bus.wdata_ext, (tbl[i].op == 2'b00) ? tbl[i].data : 32'h0);
        chk("wen_d", {31'd0, bus.wen_ext_2}, {31'd0, tbl[i].op == 2'b01});
        chk("addr_d", bus.addr_ext_2, (tbl[i].op == 2'b01) ? tbl[i].addr : 32'h0);
        chk("wdata_d", bus.wdata_ext_2, (tbl[i].op == 2'b01) ? tbl[i].data : 32'h0);
        chk("wr_no_ren", {31'd0, bus.ren_ext_2}, 32'd0);
        tick();
        chk("wr_ready_back", {31'd0, bus.cmd_ready}, 32'd1);
        chk("wr_one_cycle", {30'd0, bus.wen_ext, bus.wen_ext_2}, 32'd0);
      end
    end

    // read with a 5-cycle response stall
    send_cmd(2'b10, 32'h14, 32'h0);
    do_read(32'h14, 32'h1234_5678, 5);

    // slower sram on the second loader
    bus3.cmd_valid = 1'b1; bus3.cmd_op = 2'b10; bus3.cmd_addr = 32'h10; bus3.rsp_ready = 1'b1;
    tick();
    bus3.cmd_valid = 1'b0;
    n3 = 0;
    for (int i = 0; i < 10 && !bus3.rsp_valid; i++) begin
      if (bus3.ren_ext_2) n3++;
      tick();
    end
    chk("lat3_len", n3, RD_LAT3);
    chk("lat3_valid", {31'd0, bus3.rsp_valid}, 32'd1);
    chk("lat3_data", bus3.rsp_data, 32'hDEAD_BEEF);
    tick();
    bus3.rsp_ready = 1'b0;
    chk("lat3_drop", {31'd0, bus3.rsp_valid}, 32'd0);

    // runs
    do_run(32'd7, 7);
    do_run(32'd0, 0);
    do_run(32'h0001_0000, 65535);

    // back-to-back writes with cmd_valid held high
    baddr[0] = 32'h100; baddr[1] = 32'h104; baddr[2] = 32'h108;
    got_n = 0; k = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_addr = baddr[0]; bus.cmd_data = 32'hA0;
    for (int c = 0; c < 12; c++) begin
      rdy = bus.cmd_ready;
      tick();
      if (rdy && bus.cmd_valid) begin
        k++;
        if (k < 3) begin
          bus.cmd_addr = baddr[k];
          bus.cmd_data = 32'hA0 + k;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (bus.wen_ext) begin
        if (got_n < 3) begin
          got_a[got_n] = bus.addr_ext;
          got_c[got_n] = c;
        end
        got_n++;
      end
    end
    chk("b2b_accepts", k, 3);
    chk("b2b_writes", got_n, 3);
    for (int i = 0; i < 3; i++) chk("b2b_addr", got_a[i], baddr[i]);
    chk("b2b_gap0", got_c[1] - got_c[0], 2);
    chk("b2b_gap1", got_c[2] - got_c[1], 2);

    // asynchronous reset in the third cycle of a 10-cycle run
    send_cmd(2'b11, 32'h0, 32'd10);
    tick();
    tick();
    chk("mid_run_enable", {31'd0, bus.enable}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_enable", {31'd0, bus.enable}, 32'd0);
    chk("arst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    arst_n = 1'b1;
    dones = 0; ens = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.run_done) dones++;
      if (bus.enable) ens++;
      tick();
    end
    chk("arst_no_done", dones, 0);
    chk("arst_no_enable", ens, 0);
    chk("arst_idle", {31'd0, bus.cmd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
